// File: rtl/lm_sm_sequencer.sv
// Expands LM/SM/LA/SA into one register/address micro-op per cycle while stalling fetch.
// Micro-ops start the cycle after accept; hold freezes everything, flush abandons the sequence without done.
module lm_sm_sequencer #(
   parameter int ADDR_STEP = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] instr,
   input  logic        instr_valid,
   input  logic [15:0] base_val,
   input  logic        hold,
   input  logic        flush,
   output logic        ready,
   output logic        stall_fetch,
   output logic        uop_valid,
   output logic        uop_load,
   output logic        uop_store,
   output logic [2:0]  uop_reg,
   output logic [15:0] uop_addr,
   output logic        uop_last,
   output logic        done
);

   typedef enum logic {
      IDLE  = 1'b0,
      ISSUE = 1'b1
   } state_t;

   localparam logic [15:0] STEP = 16'(ADDR_STEP);

   state_t      state_q, state_d;
   logic [7:0]  pending_q, pending_d;
   logic [3:0]  n_q, n_d;
   logic [15:0] base_q, base_d;
   logic        load_q, load_d;
   logic        done_q, done_d;

   logic        issue;
   logic        accept;
   logic [7:0]  acc_mask;
   logic [2:0]  low_idx;
   logic        one_left;
   logic [15:0] addr;

   always_comb begin
      issue    = (state_q == ISSUE);
      accept   = instr_valid & ~issue & (instr[15:14] == 2'b11) & ~flush;
      // LA/SA (opcode bit 13 set) transfer every register regardless of the mask field
      acc_mask = instr[13] ? 8'hFF : instr[7:0];
      low_idx  = 3'd0;
      for (int i = 7; i >= 0; i--) begin
         if (pending_q[i]) low_idx = 3'(i);
      end
      one_left = (pending_q != 8'd0) && ((pending_q & (pending_q - 8'd1)) == 8'd0);
      addr     = base_q + ({12'd0, n_q} * STEP);
   end

   always_comb begin
      state_d   = state_q;
      pending_d = pending_q;
      n_d       = n_q;
      base_d    = base_q;
      load_d    = load_q;
      done_d    = 1'b0;
      if (issue) begin
         if (flush) begin
            state_d   = IDLE;
            pending_d = 8'd0;
         end else if (!hold) begin
            pending_d          = pending_q;
            pending_d[low_idx] = 1'b0;
            n_d                = n_q + 4'd1;
            if (one_left) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
         end
      end else if (accept) begin
         base_d    = base_val;
         pending_d = acc_mask;
         load_d    = ~instr[12];
         n_d       = 4'd0;
         if (acc_mask != 8'd0) state_d = ISSUE;
         else                  done_d  = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         pending_q <= 8'd0;
         n_q       <= 4'd0;
         base_q    <= 16'd0;
         load_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         pending_q <= pending_d;
         n_q       <= n_d;
         base_q    <= base_d;
         load_q    <= load_d;
         done_q    <= done_d;
      end
   end

   // Micro-op fields are forced to zero outside ISSUE so idle outputs never leak stale state.
   always_comb begin
      ready       = ~issue;
      stall_fetch = issue;
      uop_valid   = issue;
      uop_load    = issue & load_q;
      uop_store   = issue & ~load_q;
      uop_reg     = issue ? low_idx : 3'd0;
      uop_addr    = issue ? addr : 16'd0;
      uop_last    = issue & one_left;
      done        = done_q;
   end

endmodule

// File: tb/tb_lm_sm_sequencer.sv
// Drives directed and random instruction streams and checks every cycle against a queue-based model.
module tb_lm_sm_sequencer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] instr = 16'd0;
   logic        instr_valid = 1'b0;
   logic [15:0] base_val = 16'd0;
   logic        hold = 1'b0;
   logic        flush = 1'b0;
   logic        ready, stall_fetch, uop_valid, uop_load, uop_store, uop_last, done;
   logic [2:0]  uop_reg;
   logic [15:0] uop_addr;

   int n_cmp = 0;
   int n_bad = 0;

   // Model: the outstanding micro-ops of the current instruction, head first.
   int          q_reg[$];
   logic [15:0] q_addr[$];
   logic        m_load = 1'b0;
   logic        m_done = 1'b0;

   always #5 clk = ~clk;

   lm_sm_sequencer #(.ADDR_STEP(1)) dut (
      .clk(clk), .rst_n(rst_n), .instr(instr), .instr_valid(instr_valid),
      .base_val(base_val), .hold(hold), .flush(flush), .ready(ready),
      .stall_fetch(stall_fetch), .uop_valid(uop_valid), .uop_load(uop_load),
      .uop_store(uop_store), .uop_reg(uop_reg), .uop_addr(uop_addr),
      .uop_last(uop_last), .done(done)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got %0h, expected %0h", tag, $time, got, exp);
      end
   endtask

   task automatic compare_all();
      logic v;
      v = (q_reg.size() != 0);
      check("ready", 32'(ready), 32'(!v));
      check("stall_fetch", 32'(stall_fetch), 32'(v));
      check("uop_valid", 32'(uop_valid), 32'(v));
      check("uop_load", 32'(uop_load), 32'(v & m_load));
      check("uop_store", 32'(uop_store), 32'(v & ~m_load));
      check("done", 32'(done), 32'(m_done));
      if (v) begin
         check("uop_reg", 32'(uop_reg), 32'(q_reg[0]));
         check("uop_addr", 32'(uop_addr), 32'(q_addr[0]));
         check("uop_last", 32'(uop_last), 32'(q_reg.size() == 1));
      end
   endtask

   task automatic model_reset();
      q_reg.delete();
      q_addr.delete();
      m_load = 1'b0;
      m_done = 1'b0;
   endtask

   task automatic model_step(input logic v, input logic [15:0] ins, input logic [15:0] b,
                             input logic h, input logic f);
      logic       nd;
      logic [7:0] mask;
      int         k;
      nd = 1'b0;
      if (q_reg.size() != 0) begin
         if (f) begin
            q_reg.delete();
            q_addr.delete();
         end else if (!h) begin
            if (q_reg.size() == 1) nd = 1'b1;
            void'(q_reg.pop_front());
            void'(q_addr.pop_front());
         end
      end else if (v && ins[15:14] == 2'b11 && !f) begin
         mask   = ins[13] ? 8'hFF : ins[7:0];
         m_load = (ins[15:12] == 4'hC) || (ins[15:12] == 4'hE);
         k      = 0;
         for (int i = 0; i < 8; i++) begin
            if (mask[i]) begin
               q_reg.push_back(i);
               q_addr.push_back(16'(b + 16'(k)));
               k++;
            end
         end
         if (mask == 8'd0) nd = 1'b1;
      end
      m_done = nd;
   endtask

   // One cycle: check outputs at the falling edge, then drive this cycle's inputs.
   task automatic cyc(input logic v, input logic [15:0] ins, input logic [15:0] b,
                      input logic h, input logic f);
      @(negedge clk);
      compare_all();
      instr_valid = v;
      instr       = ins;
      base_val    = b;
      hold        = h;
      flush       = f;
      model_step(v, ins, b, h, f);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 16'd0, 16'd0, 1'b0, 1'b0);
   endtask

   initial begin
      logic [3:0]  opc;
      logic [7:0]  msk;
      int          r;
      model_reset();
      #12;
      check("reset_ready", 32'(ready), 32'd1);
      check("reset_valid", 32'(uop_valid), 32'd0);
      check("reset_stall", 32'(stall_fetch), 32'd0);
      check("reset_done", 32'(done), 32'd0);
      check("reset_addr", 32'(uop_addr), 32'd0);
      rst_n = 1'b1;
      idle(2);

      // LM mask 85 from 0100
      cyc(1'b1, 16'hC285, 16'h0100, 1'b0, 1'b0);
      idle(5);
      // SA from FFFE, wrapping addresses
      cyc(1'b1, 16'hF000, 16'hFFFE, 1'b0, 1'b0);
      idle(10);
      // SM mask 12 with two hold cycles on the first micro-op
      cyc(1'b1, 16'hD412, 16'h2000, 1'b0, 1'b0);
      cyc(1'b0, 16'd0, 16'd0, 1'b1, 1'b0);
      cyc(1'b0, 16'd0, 16'd0, 1'b1, 1'b0);
      idle(5);
      // LM with empty mask
      cyc(1'b1, 16'hC000, 16'h1234, 1'b0, 1'b0);
      idle(3);
      // LA flushed on its third micro-op
      cyc(1'b1, 16'hE200, 16'h0040, 1'b0, 1'b0);
      idle(2);
      cyc(1'b0, 16'd0, 16'd0, 1'b1, 1'b1);
      idle(3);
      // flush in IDLE blocks accept
      cyc(1'b1, 16'hC2FF, 16'h0040, 1'b0, 1'b1);
      idle(2);
      // ADD and LW pass untouched
      cyc(1'b1, 16'h0123, 16'h5555, 1'b0, 1'b0);
      cyc(1'b1, 16'h4ABC, 16'h5555, 1'b0, 1'b0);
      idle(2);
      // back-to-back: accept again in the done cycle
      cyc(1'b1, 16'hC203, 16'h0300, 1'b0, 1'b0);
      idle(2);
      cyc(1'b1, 16'hD280, 16'h0400, 1'b0, 1'b0);
      idle(3);

      // LA interrupted by asynchronous reset mid-sequence
      cyc(1'b1, 16'hE000, 16'h0800, 1'b0, 1'b0);
      idle(2);
      @(posedge clk);
      #2;
      rst_n       = 1'b0;
      instr_valid = 1'b0;
      #1;
      check("rst_mid_ready", 32'(ready), 32'd1);
      check("rst_mid_valid", 32'(uop_valid), 32'd0);
      check("rst_mid_stall", 32'(stall_fetch), 32'd0);
      check("rst_mid_load", 32'(uop_load), 32'd0);
      check("rst_mid_done", 32'(done), 32'd0);
      check("rst_mid_addr", 32'(uop_addr), 32'd0);
      model_reset();
      #1;
      rst_n = 1'b1;
      idle(3);

      for (int c = 0; c < 3000; c++) begin
         r   = $urandom_range(0, 9);
         opc = (r < 5) ? 4'(4'hC + 4'(r % 4)) : 4'($urandom_range(0, 11));
         msk = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom);
         cyc(($urandom_range(0, 9) < 7), {opc, 4'($urandom), msk}, 16'($urandom),
             ($urandom_range(0, 4) == 0), ($urandom_range(0, 29) == 0));
      end
      idle(12);
      @(negedge clk);
      compare_all();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/lm_sm_sequencer.md
# lm_sm_sequencer

Micro-op sequencer for the multi-register memory instructions LM, SM, LA and SA. It sits beside the decode stage. When it accepts one of these instructions, it stalls fetch and emits one register/address micro-op per cycle into the register-read/execute path. Single-transfer instructions pass untouched.

## Interface
- ADDR_STEP, 1: address increment between consecutive transfers; memory is 16-bit word addressed.
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- instr  in  16  instruction currently in decode. Fields: opcode [15:12], ra [11:9], register mask [7:0].
- instr_valid  in  1  instr is valid this cycle.
- base_val  in  16  current value of R[ra], supplied by the register file in the accept cycle.
- hold  in  1  downstream stall; freezes micro-op outputs and sequencing.
- flush  in  1  synchronous abort from an older branch/jump.
- ready  out  1  high in IDLE; a multi instruction is accepted only when high.
- stall_fetch  out  1  registered; high in every ISSUE cycle.
- uop_valid  out  1  registered; a micro-op is presented.
- uop_load  out  1  micro-op is a load (LM/LA).
- uop_store  out  1  micro-op is a store (SM/SA).
- uop_reg  out  3  register written or read by this micro-op.
- uop_addr  out  16  memory address of this micro-op.
- uop_last  out  1  final micro-op of the instruction.
- done  out  1  one-cycle pulse when the final micro-op is consumed.

## Operation
- Multi opcodes:
  - 1100 LM: load, mask = instr[7:0].
  - 1101 SM: store, mask = instr[7:0].
  - 1110 LA: load, mask = 8'hFF.
  - 1111 SA: store, mask = 8'hFF.
- Any other opcode is ignored. The block stays in IDLE and no output changes.
- Mask bit i selects register Ri. Registers are transferred in ascending index order.
- Accept condition: instr_valid & ready & multi opcode & ~flush. On accept, the block captures:
  - base_val into base_reg,
  - the mask into pending,
  - the load/store type,
  - transfer index n = 0.
- Address of the n-th transfer is base_reg + n*ADDR_STEP, modulo 2^16 (wraps FFFF→0000).
- Base is captured once. Loading into R[ra] mid-sequence does not change later addresses.
- States:
  - IDLE: ready=1, uop_valid=0. On accept with a non-zero mask → ISSUE. On accept with mask 0 → stay in IDLE; done pulses next cycle; no micro-op is issued.
  - ISSUE: uop_reg = lowest set bit of pending; uop_last = exactly one bit set in pending.
- When ~hold in ISSUE: clear that bit in pending and increment n. If uop_last, → IDLE and pulse done in the first IDLE cycle.
- When hold in ISSUE: all outputs and state stay frozen.
- Flush in ISSUE: → IDLE at the next edge, pending cleared, no done. Flush in IDLE blocks accept. Flush has priority over hold.
- Reset values of all outputs are 0, except ready=1. State resets to IDLE, pending=0, n=0, base_reg=0.
- Reset mid-sequence: the sequence is abandoned immediately (asynchronous), with no done.

## Timing
- Accept at edge k: the first micro-op is valid during cycle k+1, with stall_fetch=1 from cycle k+1.
- With hold=0, micro-ops are issued one per cycle. An N-bit mask occupies cycles k+1..k+N.
- done=1 in cycle k+N+1. ready=1 and stall_fetch=0 in the same cycle.
- A new multi instruction can be accepted at the end of cycle k+N+1.
- Each hold cycle extends the sequence by exactly one cycle.
- The transfer index n needs 4 bits (0..8). Address arithmetic is 16-bit unsigned, carry discarded.
- uop_load and uop_store are mutually exclusive and both are 0 when uop_valid=0.

## Test plan
- LM, mask 8'h85, base_val 16'h0100:
  - Required micro-ops: R0@0100, R2@0101, R7@0102, all uop_load=1.
  - uop_last only on the third micro-op; done one cycle later.
  - stall_fetch high for exactly 3 cycles.
- SA, base_val 16'hFFFE: stores R0..R7 at FFFE, FFFF, 0000 … 0005; uop_last with R7; 8 stall cycles.
- SM, mask 8'h12, hold high for 2 cycles during the first micro-op:
  - R1@base is held unchanged for those cycles, then R4@base+1 follows.
  - The total sequence takes 4 cycles.
- LM with mask 8'h00: no uop_valid; done pulses once; stall_fetch never asserts.
- LA with flush asserted on the 3rd micro-op: IDLE at the next edge, no done. Repeat with rst_n low mid-sequence: all outputs are 0 immediately and ready=1.
- ADD and LW instructions with instr_valid=1: ready stays 1; uop_valid, stall_fetch and done stay 0.
